instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have one parameter: ADDR_W, default 6, instruction-memory word-address width (capacity 2**ADDR_W words).
REQ-002 clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  single-cycle load request; nwords is sampled in the same cycle.
REQ-005 nwords  input  ADDR_W+1  number of 32-bit instruction words to load.
REQ-006 byte_in  input  8  incoming instruction byte, big-endian; the first byte carries bits 31:24.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  loader accepts a byte; a transfer occurs when byte_valid && byte_ready.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  word address of the write.
REQ-011 imem_wd  output  32  instruction word to write.
REQ-012 count  output  ADDR_W+1  words written in the current load.
REQ-013 busy, done, error  output  1 each  load status flags.
REQ-014 bad_op  output  6  opcode that caused an error; 0 otherwise.

Function
REQ-015 The FSM SHALL have the states IDLE, RECV, WRITE, DONE and ERR.
REQ-016 IDLE: byte_ready=0. On start with nwords==0, next state DONE. On start with nwords > 2**ADDR_W, next state ERR with bad_op=0. On any other start, next state RECV, with imem_addr=0, count=0 and the byte index at 0.
REQ-017 RECV: byte_ready=1 and busy=1. Each transfer SHALL shift the byte into the word buffer, MSB first, and increment the byte index (0..3).
REQ-018 The transfer of the 4th byte SHALL move the FSM to WRITE on the next edge; bytes offered while in WRITE SHALL NOT be accepted.
REQ-019 WRITE SHALL last exactly one cycle: imem_we=1, imem_wd=assembled word, imem_addr=current address. count and imem_addr SHALL increment at the end of the cycle.
REQ-020 After WRITE: if the incremented count equals the latched nwords, next state DONE; otherwise next state RECV with the byte index at 0.
REQ-021 Throughput SHALL be one word per 5 cycles when byte_valid is held high: 4 accept cycles plus 1 write cycle.
REQ-022 DONE: done=1, busy=0, byte_ready=0, and count holds its final value. A start in DONE SHALL begin a new load exactly as from IDLE.
REQ-023 ERR: error=1 and busy=0. The state and bad_op SHALL be held until reset or start; start behaves as from IDLE and clears error and bad_op.
REQ-024 start asserted during RECV or WRITE SHALL be ignored.
REQ-025 imem_addr SHALL never wrap, because nwords is bounded by REQ-016.
REQ-026 imem_we SHALL be 0 in every state except WRITE.

Reset
REQ-027 On reset, the block SHALL enter state IDLE, and the next edge SHALL leave byte_ready=0, imem_we=0, imem_addr=0, imem_wd=0, count=0, busy=0, done=0, error=0 and bad_op=0.
REQ-028 Reset asserted during RECV or WRITE SHALL abandon the load immediately: no further writes occur and the partial word is discarded.

Configuration
REQ-029 With OPCODE_CHECK_EN defined, the first byte of each word SHALL be checked on acceptance: if byte_in[7:2] is not in {000000, 100011, 101011, 000100, 001000, 000010}, the next state SHALL be ERR, bad_op SHALL be set to byte_in[7:2], and no write SHALL occur for that word. Words already written SHALL remain written.
REQ-030 Without OPCODE_CHECK_EN, every word SHALL be written unchecked, and bad_op SHALL be constant 0.

Structure
REQ-031 The shared package mips_pkg SHALL hold the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J) and the loader state enum.
REQ-032 The legal-opcode test SHALL be one combinational sub-module, op_check (6-bit op in, 1-bit legal out), instantiated only under OPCODE_CHECK_EN.

Verification
REQ-033 Basic load: start with nwords=2, bytes 8C 01 00 04 20 02 00 05 -> imem_we pulses at addr 0 with wd=8C010004 and at addr 1 with wd=20020005; done=1; count=2.
REQ-034 Gaps and zero length: byte_valid toggling 1/0 with nwords=1 -> exactly one write after the 4th accepted byte. start with nwords=0 -> DONE on the next cycle with no imem_we.
REQ-035 Oversize request: ADDR_W=6 and nwords=65 -> ERR, error=1, bad_op=0, no writes. nwords=64 -> 64 writes, with the last at addr 63.
REQ-036 Illegal opcode (OPCODE_CHECK_EN): second word starting FC -> first word written, then error=1 and bad_op=111111; a subsequent start clears error.
REQ-037 Reset mid-load: reset after 2 bytes of word 0 -> all outputs zero, no imem_we. A fresh start then loads correctly from addr 0.
REQ-038 Start during RECV: start pulsed after 1 byte with a different nwords -> ignored, and the original load completes unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: the six legal primary opcodes and the instruction-loader state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/op_check.sv
// Combinational legal-opcode test for the instruction loader (used only when OPCODE_CHECK_EN is defined).
module op_check
  import mips_pkg::*;
(
  input  logic [5:0] op,
  output logic       legal
);

  always_comb begin
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: packs big-endian bytes into 32-bit words and writes them to imem.
// Optional macro OPCODE_CHECK_EN rejects words whose first byte carries an unknown opcode.
module instr_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   nwords,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [5:0]        bad_op
);

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  loader_state_e     state_q, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q, count_inc, nwords_q;
  logic [1:0]        idx_q;
  logic [31:0]       word_q;
  logic              can_start, xfer, first_bad, op_legal;

  // Byte stream: a byte moves only in a cycle where byte_valid && byte_ready are both high;
  // byte_ready is high exactly in RECV, so the source may hold or drop byte_valid freely.
  assign xfer      = byte_valid && (state_q == ST_RECV);
  assign can_start = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERR});
  assign first_bad = xfer && (idx_q == 2'd0) && !op_legal;
  assign count_inc = count_q + (ADDR_W+1)'(1);

`ifdef OPCODE_CHECK_EN
  logic [5:0] bad_op_q;

  op_check u_op_check (
    .op    (byte_in[7:2]),
    .legal (op_legal)
  );

  always_ff @(posedge clk) begin
    if (reset || can_start) bad_op_q <= '0;
    else if (first_bad)     bad_op_q <= byte_in[7:2];
  end

  assign bad_op = bad_op_q;
`else
  assign op_legal = 1'b1;
  assign bad_op   = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (nwords == '0)           state_next = ST_DONE;
          else if (nwords > CAPACITY) state_next = ST_ERR;
          else                        state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        if (first_bad)                      state_next = ST_ERR;
        else if (xfer && (idx_q == 2'd3))   state_next = ST_WRITE;
      end
      ST_WRITE: state_next = (count_inc == nwords_q) ? ST_DONE : ST_RECV;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == ST_RECV);
    imem_we    = (state_q == ST_WRITE);
    imem_wd    = (state_q == ST_WRITE) ? word_q : 32'd0;
    busy       = (state_q == ST_RECV) || (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
    error      = (state_q == ST_ERR);
  end

  assign imem_addr = addr_q;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      count_q  <= '0;
      nwords_q <= '0;
      idx_q    <= '0;
      word_q   <= '0;
    end else if (can_start) begin
      addr_q   <= '0;
      count_q  <= '0;
      nwords_q <= nwords;
      idx_q    <= '0;
    end else if (xfer && !first_bad) begin
      word_q <= {word_q[23:0], byte_in};
      idx_q  <= idx_q + 2'd1;
    end else if (state_q == ST_WRITE) begin
      count_q <= count_inc;
      // A full-capacity load ends on the top address; hold it there rather than wrap to 0.
      if (addr_q != '1) addr_q <= addr_q + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (ADDR_W=6); honours OPCODE_CHECK_EN when defined.
module tb_instr_loader;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   nwords = '0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready, imem_we, busy, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic [ADDR_W:0]   count;
  logic [5:0]        bad_op;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_wd_q[$];
  int                wr_cyc_q[$];
  logic [31:0]       exp_q[$];

  instr_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .nwords     (nwords),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bad_op     (bad_op)
  );

  // Clock and reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, wanted summary first");
    $fatal(1, "watchdog");
  end

  // Write monitor
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_wd_q.push_back(imem_wd);
      wr_cyc_q.push_back(cyc);
    end
  end

  // Driver tasks
  task automatic clear_log();
    wr_addr_q.delete();
    wr_wd_q.delete();
    wr_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    @(posedge clk); #1;
    start = 1'b1; nwords = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    byte_in = b; byte_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); got = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL byte_handshake: byte %h never accepted, byte_ready=0 wanted 1", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic wait_end(input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (done === 1'b1) || (error === 1'b1);
    end
    if (!hit) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_end: no done/error within %0d cycles", budget);
    end
  endtask

  // Scoreboard: compare logged writes in order against exp_q (addresses run 0,1,2...)
  task automatic check_writes(input string name);
    n_cmp++;
    if (wr_wd_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: %0d writes, wanted %0d", name, wr_wd_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== ADDR_W'(i) || wr_wd_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s_write%0d: addr=%0d wd=%h, wanted addr=%0d wd=%h",
                   name, i, wr_addr_q[i], wr_wd_q[i], i, exp_q[i]);
        end
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({byte_ready, imem_we, imem_addr, imem_wd, count, busy, done, error, bad_op} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b we=%b addr=%0d wd=%h count=%0d busy=%b done=%b err=%b bad_op=%h, wanted all 0",
               byte_ready, imem_we, imem_addr, imem_wd, count, busy, done, error, bad_op);
    end
  endtask

  task automatic test_basic();
    clear_log();
    do_start(7'd2);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || byte_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_recv: busy=%b ready=%b, wanted 1 1", busy, byte_ready);
    end
    exp_q.push_back(32'h8C010004);
    exp_q.push_back(32'h20020005);
    @(posedge clk); #1;
    send_word(32'h8C010004);
    send_word(32'h20020005);
    wait_end(20);
    check_writes("basic");
    n_cmp++;
    if (done !== 1'b1 || count !== 7'd2 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: done=%b count=%0d busy=%b ready=%b, wanted 1 2 0 0",
                         done, count, busy, byte_ready);
    end
    n_cmp++;
    if (wr_cyc_q.size() != 2 || (wr_cyc_q[1] - wr_cyc_q[0]) != 5) begin
      n_fail++; $display("FAIL basic_throughput: write spacing wrong (%0d writes), wanted 2 writes 5 cycles apart",
                         wr_cyc_q.size());
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w;
    w = 32'h20030007;
    clear_log();
    do_start(7'd1);
    for (int k = 3; k >= 0; k--) begin
      if (k == 0) begin
        n_cmp++;
        if (wr_wd_q.size() !== 0) begin
          n_fail++; $display("FAIL gaps_early: %0d writes before 4th byte, wanted 0", wr_wd_q.size());
        end
      end
      send_byte(w[k*8 +: 8]);
      @(posedge clk); #1;
    end
    wait_end(20);
    exp_q.push_back(w);
    check_writes("gaps");
  endtask

  task automatic test_zero();
    clear_log();
    pulse_reset();
    do_start(7'd0);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || count !== '0 || busy !== 1'b0 || wr_wd_q.size() !== 0) begin
      n_fail++; $display("FAIL zero_len: done=%b count=%0d busy=%b writes=%0d, wanted 1 0 0 0",
                         done, count, busy, wr_wd_q.size());
    end
  endtask

  task automatic test_oversize();
    clear_log();
    do_start(7'd65);
    @(negedge clk);
    n_cmp++;
    if (error !== 1'b1 || bad_op !== 6'd0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL oversize_err: error=%b bad_op=%h done=%b busy=%b, wanted 1 00 0 0",
                         error, bad_op, done, busy);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (error !== 1'b1 || wr_wd_q.size() !== 0) begin
      n_fail++; $display("FAIL oversize_hold: error=%b writes=%0d, wanted 1 0", error, wr_wd_q.size());
    end
  endtask

  task automatic test_full64();
    clear_log();
    do_start(7'd64);
    @(negedge clk);
    n_cmp++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL full_start: error=%b busy=%b, wanted 0 1", error, busy);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({8'h20, 8'(i), 8'h00, 8'(i)});
      send_word({8'h20, 8'(i), 8'h00, 8'(i)});
    end
    wait_end(20);
    check_writes("full64");
    n_cmp++;
    if (done !== 1'b1 || count !== 7'd64 || wr_addr_q.size() == 0 || wr_addr_q[$] !== 6'd63) begin
      n_fail++; $display("FAIL full_end: done=%b count=%0d, wanted done=1 count=64 last addr 63", done, count);
    end
  endtask

  task automatic test_illegal_op();
    clear_log();
    do_start(7'd2);
    send_word(32'h8C010004);
    exp_q.push_back(32'h8C010004);
`ifdef OPCODE_CHECK_EN
    send_byte(8'hFC);
    @(negedge clk);
    check_writes("badop");
    n_cmp++;
    if (error !== 1'b1 || bad_op !== 6'b111111 || busy !== 1'b0) begin
      n_fail++; $display("FAIL badop_err: error=%b bad_op=%b busy=%b, wanted 1 111111 0", error, bad_op, busy);
    end
    clear_log();
    do_start(7'd1);
    @(negedge clk);
    n_cmp++;
    if (error !== 1'b0 || bad_op !== 6'd0) begin
      n_fail++; $display("FAIL badop_clear: error=%b bad_op=%b, wanted 0 000000", error, bad_op);
    end
    @(posedge clk); #1;
    send_word(32'h00000000);
    exp_q.push_back(32'h00000000);
    wait_end(20);
    check_writes("badop_reload");
`else
    send_word(32'hFC000001);
    exp_q.push_back(32'hFC000001);
    wait_end(20);
    check_writes("nocheck");
    n_cmp++;
    if (error !== 1'b0 || bad_op !== 6'd0 || done !== 1'b1) begin
      n_fail++; $display("FAIL nocheck_flags: error=%b bad_op=%b done=%b, wanted 0 000000 1", error, bad_op, done);
    end
`endif
  endtask

  task automatic test_reset_midload();
    clear_log();
    do_start(7'd2);
    send_byte(8'hAC);
    send_byte(8'h02);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({byte_ready, imem_we, imem_addr, imem_wd, count, busy, done, error, bad_op} !== '0 ||
        wr_wd_q.size() !== 0) begin
      n_fail++; $display("FAIL midreset_outputs: ready=%b we=%b count=%0d busy=%b writes=%0d, wanted all 0",
                         byte_ready, imem_we, count, busy, wr_wd_q.size());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_start(7'd1);
    send_word(32'hAC020008);
    exp_q.push_back(32'hAC020008);
    wait_end(20);
    check_writes("midreset_reload");
  endtask

  task automatic test_start_during_recv();
    clear_log();
    do_start(7'd2);
    send_byte(8'h10);
    start = 1'b1; nwords = 7'd1;
    @(posedge clk); #1;
    start = 1'b0; nwords = 7'd0;
    send_byte(8'h22);
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(32'h08000010);
    exp_q.push_back(32'h10220003);
    exp_q.push_back(32'h08000010);
    wait_end(20);
    check_writes("start_recv");
    n_cmp++;
    if (done !== 1'b1 || count !== 7'd2) begin
      n_fail++; $display("FAIL start_recv_done: done=%b count=%0d, wanted 1 2", done, count);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_zero();
    test_oversize();
    test_full64();
    test_illegal_op();
    test_reset_midload();
    test_start_during_recv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
